// File: rtl/timer_counter.sv
// Counting core of the timer IP: 2^N prescaler, 64-bit up-counter with split
// software loads, and a debug-halt state that freezes counter and prescaler.
module timer_counter #(
  parameter int CNT_W   = 64,
  parameter int DIV_MAX = 8,
  parameter int PS_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             dbg_mode,
  input  logic             halt_req,
  input  logic             ld_lo,
  input  logic             ld_hi,
  input  logic [31:0]      ld_data,
  output logic [CNT_W-1:0] cnt_value,
  output logic             cnt_tick,
  output logic             cnt_ovf,
  output logic             halt_ack
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tick_q, tick_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic             div_en_q, div_en_d;
  logic [3:0]       div_val_q, div_val_d;

  logic             halt;
  logic             div_chg;
  logic [3:0]       div_n;
  logic [PS_W:0]    ps_pow;
  logic [PS_W:0]    ps_full;
  logic [PS_W-1:0]  ps_mask;
  logic [PS_W-1:0]  ps_eff;
  logic             ps_hit;
  logic             inc;
  logic             ld;
  logic             clr;

  // Terminal prescaler value for the effective exponent; zero when the
  // prescaler is bypassed so every RUN cycle hits.
  always_comb begin
    div_n   = (div_val > 4'(DIV_MAX)) ? 4'(DIV_MAX) : div_val;
    ps_pow  = (PS_W+1)'(1) << div_n;
    ps_full = ps_pow - (PS_W+1)'(1);
    ps_mask = (div_en && (div_val != 4'd0)) ? ps_full[PS_W-1:0] : '0;
  end

  // A config change restarts the phase in the very cycle the new value is seen.
  assign div_chg = (div_en != div_en_q) || (div_val != div_val_q);
  assign ps_eff  = div_chg ? '0 : ps_q;
  assign ps_hit  = (ps_eff == ps_mask);
  assign halt    = dbg_mode & halt_req;
  assign ld      = ld_lo | ld_hi;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (timer_en) state_d = RUN;
      RUN:     if (!timer_en) state_d = IDLE;
               else if (halt) state_d = HALT;
      HALT:    if (!timer_en) state_d = IDLE;
               else if (!halt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Counting is gated by the next state so a halt request freezes at once
  // and the enabling edge already counts.
  always_comb begin
    inc  = 1'b0;
    ps_d = ps_q;
    case (state_d)
      RUN: begin
        inc  = ps_hit;
        ps_d = ps_hit ? '0 : ps_eff + PS_W'(1);
      end
      HALT:    ps_d = ps_eff;
      default: ps_d = '0;
    endcase
  end

  assign clr = (state_q == RUN) && (state_d == IDLE);

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    ovf_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      if (ld_lo) cnt_d[31:0]       = ld_data;
      if (ld_hi) cnt_d[CNT_W-1:32] = ld_data;
    end else if (inc) begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b1;
      ovf_d  = &cnt_q;
    end
  end

  assign ack_d     = (state_d == HALT);
  assign div_en_d  = div_en;
  assign div_val_d = div_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ps_q      <= '0;
      tick_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      div_en_q  <= 1'b0;
      div_val_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ps_q      <= ps_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
      ack_q     <= ack_d;
      div_en_q  <= div_en_d;
      div_val_q <= div_val_d;
    end
  end

  assign cnt_value = cnt_q;
  assign cnt_tick  = tick_q;
  assign cnt_ovf   = ovf_q;
  assign halt_ack  = ack_q;

endmodule
